// File: rtl/tb_irq_pkg.sv
// Shared types and constants for the interrupt-stimulus scheduler.
// Holds the channel FSM states, the LFSR taps and the default commit PCs.
package tb_irq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ASSERT,
        ST_STOP
    } chan_st_e;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam logic [31:0] DEF_PC_START   = 32'h8000015C;
    localparam logic [31:0] DEF_PC_EXT_ACK = 32'h800000A6;
    localparam logic [31:0] DEF_PC_SFT_ACK = 32'h800000BE;
    localparam logic [31:0] DEF_PC_TMR_ACK = 32'h800000D6;
    localparam logic [31:0] DEF_PC_TOHOST  = 32'h80000086;

    // Galois step: a nonzero state never maps to zero.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? LFSR_TAPS : 16'h0000);
    endfunction

    function automatic logic [15:0] rotr16(input logic [15:0] v,
                                           input int unsigned n);
        logic [31:0] w;
        w = {v, v} >> n;
        return w[15:0];
    endfunction

endpackage

// File: rtl/tb_irq_chan.sv
// One interrupt channel: IDLE/WAIT/ASSERT/STOP FSM, countdown, irq register.
// Ports: clk, rst_n, enable_i, start_i, ack_i, stop_i, dly_i -> irq_o, st_o.
module tb_irq_chan
    import tb_irq_pkg::*;
#(
    parameter int WAIT_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable_i,
    input  logic              start_i,
    input  logic              ack_i,
    input  logic              stop_i,
    input  logic [WAIT_W:0]   dly_i,
    output logic              irq_o,
    output chan_st_e          st_o
);

    chan_st_e          st_q;
    logic [WAIT_W:0]   cnt_q;
    logic              irq_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q  <= ST_IDLE;
            cnt_q <= '0;
            irq_q <= 1'b0;
        end else if (!enable_i) begin
            st_q  <= ST_IDLE;
            irq_q <= 1'b0;
        end else begin
            unique case (st_q)
                ST_IDLE: begin
                    if (start_i) begin
                        cnt_q <= dly_i;
                        st_q  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Rise on the edge where the count reads 1, so the
                    // line goes high D edges after the load.
                    if (cnt_q == (WAIT_W+1)'(1)) begin
                        st_q  <= ST_ASSERT;
                        irq_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - (WAIT_W+1)'(1);
                    end
                end
                ST_ASSERT: begin
                    if (ack_i) begin
                        irq_q <= 1'b0;
                        cnt_q <= dly_i;
                        st_q  <= stop_i ? ST_STOP : ST_WAIT;
                    end
                end
                ST_STOP: begin
                    irq_q <= 1'b0;
                end
            endcase
        end
    end

    assign irq_o = irq_q;
    assign st_o  = st_q;

endmodule

// File: rtl/tb_irq_sched.sv
// Interrupt-stimulus scheduler: drives ext/sft/tmr irq lines with random
// gaps until each handler commits its ack PC; stops after enough tohost
// writes. Ports: clk, rst_n, enable, cmt_valid, cmt_pc -> ext_irq,
// sft_irq, tmr_irq, armed, tohost_cnt, done.
module tb_irq_sched
    import tb_irq_pkg::*;
#(
    parameter int                PC_W       = 32,
    parameter logic [PC_W-1:0]   PC_START   = PC_W'(DEF_PC_START),
    parameter logic [PC_W-1:0]   PC_EXT_ACK = PC_W'(DEF_PC_EXT_ACK),
    parameter logic [PC_W-1:0]   PC_SFT_ACK = PC_W'(DEF_PC_SFT_ACK),
    parameter logic [PC_W-1:0]   PC_TMR_ACK = PC_W'(DEF_PC_TMR_ACK),
    parameter logic [PC_W-1:0]   PC_TOHOST  = PC_W'(DEF_PC_TOHOST),
    parameter logic [31:0]       STOP_CNT   = 32'd32,
    parameter int                WAIT_W     = 10,
    parameter int                FIXED_DLY  = 0,
    parameter logic [15:0]       SEED       = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              cmt_valid,
    input  logic [PC_W-1:0]   cmt_pc,
    output logic              ext_irq,
    output logic              sft_irq,
    output logic              tmr_irq,
    output logic              armed,
    output logic [31:0]       tohost_cnt,
    output logic              done
);

    localparam logic [WAIT_W:0] FIX_D = (WAIT_W+1)'(FIXED_DLY);
    localparam logic [15:0]     MASK  = 16'((32'h1 << WAIT_W) - 1);

    logic [15:0] lfsr_q, lfsr_d;
    logic        armed_q, armed_d;
    logic [31:0] cnt_q, cnt_d;

    logic        arm_evt, th_evt, stop;
    logic [2:0]  ack_evt;
    logic [2:0]  irq;
    logic [2:0]  is_stop;
    logic [2:0][WAIT_W:0] dly;
    chan_st_e    st [3];

    assign arm_evt    = cmt_valid & (cmt_pc == PC_START);
    assign th_evt     = cmt_valid & (cmt_pc == PC_TOHOST);
    assign ack_evt[0] = cmt_valid & (cmt_pc == PC_EXT_ACK);
    assign ack_evt[1] = cmt_valid & (cmt_pc == PC_SFT_ACK);
    assign ack_evt[2] = cmt_valid & (cmt_pc == PC_TMR_ACK);

    // Pre-increment count decides STOP for an ack in the same cycle.
    assign stop = cnt_q > STOP_CNT;

    always_comb begin
        lfsr_d  = lfsr_step(lfsr_q);
        armed_d = enable & (armed_q | arm_evt);
        cnt_d   = cnt_q;
        if (th_evt && cnt_q != 32'hFFFF_FFFF) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q  <= SEED;
            armed_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            lfsr_q  <= lfsr_d;
            armed_q <= armed_d;
            cnt_q   <= cnt_d;
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_ch
        logic [15:0] rot;

        // Each channel sees a differently rotated view of the LFSR so
        // simultaneous reloads do not produce identical gaps.
        assign rot    = rotr16(lfsr_q, 5 * i);
        assign dly[i] = (FIXED_DLY != 0) ? FIX_D
                      : (WAIT_W+1)'(rot & MASK) + (WAIT_W+1)'(1);

        tb_irq_chan #(
            .WAIT_W (WAIT_W)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .enable_i (enable),
            .start_i  (armed_q | arm_evt),
            .ack_i    (ack_evt[i]),
            .stop_i   (stop),
            .dly_i    (dly[i]),
            .irq_o    (irq[i]),
            .st_o     (st[i])
        );

        assign is_stop[i] = (st[i] == ST_STOP);
    end

    assign ext_irq    = irq[0];
    assign sft_irq    = irq[1];
    assign tmr_irq    = irq[2];
    assign armed      = armed_q;
    assign tohost_cnt = cnt_q;
    assign done       = &is_stop;

endmodule

// File: tb/tb_tb_irq_sched.sv
// Bench for tb_irq_sched: directed fixed-delay sequence on one instance,
// then a random-gap run on a second instance with a rise-time scoreboard.
module tb_tb_irq_sched;

    localparam logic [31:0] P_START = 32'h8000015C;
    localparam logic [31:0] P_EXT   = 32'h800000A6;
    localparam logic [31:0] P_SFT   = 32'h800000BE;
    localparam logic [31:0] P_TMR   = 32'h800000D6;
    localparam logic [31:0] P_TH    = 32'h80000086;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;

    logic        en_a, cv_a;
    logic [31:0] pc_a;
    logic        ext_a, sft_a, tmr_a, armed_a, done_a;
    logic [31:0] th_a;

    logic        en_b, cv_b;
    logic [31:0] pc_b;
    logic        ext_b, sft_b, tmr_b, armed_b, done_b;
    logic [31:0] th_b;

    tb_irq_sched #(
        .FIXED_DLY (4)
    ) u_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (en_a),
        .cmt_valid  (cv_a),
        .cmt_pc     (pc_a),
        .ext_irq    (ext_a),
        .sft_irq    (sft_a),
        .tmr_irq    (tmr_a),
        .armed      (armed_a),
        .tohost_cnt (th_a),
        .done       (done_a)
    );

    tb_irq_sched #(
        .SEED (16'hACE1)
    ) u_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (en_b),
        .cmt_valid  (cv_b),
        .cmt_pc     (pc_b),
        .ext_irq    (ext_b),
        .sft_irq    (sft_b),
        .tmr_irq    (tmr_b),
        .armed      (armed_b),
        .tohost_cnt (th_b),
        .done       (done_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_nx(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic int gap_of(input logic [15:0] v, input int ch);
        logic [31:0] w;
        w = {v, v} >> (5 * ch);
        return int'(w[9:0]) + 1;
    endfunction

    // Reference LFSR and edge counter for the random instance.
    logic [15:0] lfsr_m;
    int          cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_m <= 16'hACE1;
            cyc    <= 0;
        end else begin
            lfsr_m <= lfsr_nx(lfsr_m);
            cyc    <= cyc + 1;
        end
    end

    // Called at a negedge; the commit is sampled at the next posedge.
    task automatic cmt_a(input logic [31:0] pc);
        cv_a = 1'b1;
        pc_a = pc;
        @(negedge clk);
        cv_a = 1'b0;
    endtask

    int          exp_q [3][$];
    int          last_ack [3];
    logic [31:0] ack_pc [3];
    logic [2:0]  irq_b, prev_b;
    int          n_rise;
    logic        zero_seen;
    logic        acked;

    initial begin
        rst_n = 1'b0;
        en_a  = 1'b1; cv_a = 1'b0; pc_a = '0;
        en_b  = 1'b1; cv_b = 1'b0; pc_b = '0;
        ack_pc[0] = P_EXT; ack_pc[1] = P_SFT; ack_pc[2] = P_TMR;

        repeat (3) @(negedge clk);
        check("rst_ext", ext_a, 0);
        check("rst_sft", sft_a, 0);
        check("rst_tmr", tmr_a, 0);
        check("rst_armed", armed_a, 0);
        check("rst_th", th_a, 0);
        check("rst_done", done_a, 0);
        rst_n = 1'b1;

        repeat (5) @(negedge clk);
        cmt_a(P_START);
        check("armed", armed_a, 1);
        check("arm_irq0", {ext_a, sft_a, tmr_a}, 3'b000);
        repeat (3) @(negedge clk);
        check("arm_d3", {ext_a, sft_a, tmr_a}, 3'b000);
        @(negedge clk);
        check("rise_ext", ext_a, 1);
        check("rise_sft", sft_a, 1);
        check("rise_tmr", tmr_a, 1);
        repeat (10) @(negedge clk);
        check("hold", {ext_a, sft_a, tmr_a}, 3'b111);

        cmt_a(P_EXT);
        check("ext_ack", {ext_a, sft_a, tmr_a}, 3'b011);
        repeat (3) @(negedge clk);
        check("ext_gap", ext_a, 0);
        @(negedge clk);
        check("ext_rerise", ext_a, 1);

        pc_a = P_SFT;
        cv_a = 1'b0;
        @(negedge clk);
        check("sft_novalid", sft_a, 1);
        cmt_a(P_SFT);
        check("sft_ack", sft_a, 0);
        repeat (3) @(negedge clk);
        check("sft_gap", sft_a, 0);
        @(negedge clk);
        check("sft_rerise", sft_a, 1);

        for (int i = 0; i < 33; i++) cmt_a(P_TH);
        check("th_cnt", th_a, 33);
        check("th_done0", done_a, 0);
        check("th_irqs", {ext_a, sft_a, tmr_a}, 3'b111);
        cmt_a(P_EXT);
        check("stop_ext", {ext_a, done_a}, 2'b00);
        cmt_a(P_SFT);
        cmt_a(P_TMR);
        check("stop_done", done_a, 1);
        repeat (20) @(negedge clk);
        check("stop_quiet", {ext_a, sft_a, tmr_a}, 3'b000);
        check("stop_done2", done_a, 1);

        en_a = 1'b0;
        @(negedge clk);
        check("dis_armed", armed_a, 0);
        check("dis_done", done_a, 0);
        check("dis_th", th_a, 33);
        en_a = 1'b1;
        @(negedge clk);
        cmt_a(P_START);
        repeat (4) @(negedge clk);
        check("rearm", {ext_a, sft_a, tmr_a}, 3'b111);

        #2 rst_n = 1'b0;
        #1;
        check("arst_out",
              {ext_a, sft_a, tmr_a, armed_a, done_a}, 5'b00000);
        check("arst_th", th_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("post_rst", {ext_a, sft_a, tmr_a, armed_a}, 4'b0000);

        n_rise    = 0;
        zero_seen = 1'b0;
        prev_b    = 3'b000;
        cv_b = 1'b1;
        pc_b = P_START;
        for (int ch = 0; ch < 3; ch++) begin
            exp_q[ch].push_back(cyc + 1 + gap_of(lfsr_m, ch));
            last_ack[ch] = cyc + 1;
        end
        @(negedge clk);
        for (int k = 0; k < 10000; k++) begin
            cv_b  = 1'b0;
            irq_b = {tmr_b, sft_b, ext_b};
            for (int ch = 0; ch < 3; ch++) begin
                if (irq_b[ch] && !prev_b[ch]) begin
                    n_rise++;
                    if (exp_q[ch].size() == 0) begin
                        check("sb_empty", 1, 0);
                    end else begin
                        check("rise_edge", cyc, exp_q[ch].pop_front());
                    end
                    check("gap_rng",
                          32'((cyc - last_ack[ch] >= 1) &&
                              (cyc - last_ack[ch] <= 1024)), 1);
                end
            end
            prev_b = irq_b;
            acked  = 1'b0;
            for (int ch = 0; ch < 3; ch++) begin
                if (!acked && irq_b[ch]) begin
                    acked = 1'b1;
                    cv_b  = 1'b1;
                    pc_b  = ack_pc[ch];
                    exp_q[ch].push_back(cyc + 1 + gap_of(lfsr_m, ch));
                    last_ack[ch] = cyc + 1;
                end
            end
            if (u_b.lfsr_q == 16'h0000) zero_seen = 1'b1;
            @(negedge clk);
        end
        cv_b = 1'b0;
        check("rises_min", 32'(n_rise >= 30), 1);
        check("lfsr_nz", zero_seen, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
